// File: rtl/serial_adder8.sv
// Bit-serial adder/subtractor: one full-adder cell, registered carry, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, psum_q, sum_q;
  logic             carry_q, cout_q, ovf_q, zero_q;
  logic [CW-1:0]    cnt_q;

  logic             fa_s, fa_c, last_bit;
  logic [WIDTH-1:0] sum_next, b_load;
  logic             c_load;

  assign fa_s     = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_c     = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign sum_next = {fa_s, psum_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = op_sub ? ~b : b;
  assign c_load = op_sub ? 1'b1 : cin;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign b_load = b;
  assign c_load = cin;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b_load;
            carry_q <= c_load;
            cnt_q   <= '0;
          end
        end
        StShift: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          psum_q  <= sum_next;
          carry_q <= fa_c;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            // carry_q here is the carry into the MSB, so ovf is carry-in XOR carry-out
            sum_q  <= sum_next;
            cout_q <= fa_c;
            ovf_q  <= carry_q ^ fa_c;
            zero_q <= (sum_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: doc/serial_adder8.md
# serial_adder8

Bit-serial adder/subtractor built around a single full-adder cell plus a registered carry. It consumes two WIDTH-bit operands and processes them one bit per clock, LSB first. It produces a registered sum, carry-out and flags for the ALU result stage. It is the area-minimal alternative to the ripple-carry datapath, and it is the sequential stage that directly wraps the full-adder cell.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in for add, captured on accepted start
- op_sub  input  1  1 = A − B (see Configuration), captured on accepted start
- busy  output  1  high while bits are being shifted
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  registered result
- cout  output  1  final carry-out (for subtract, 1 = no borrow)
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
- zero  output  1  sum == 0

## Operation
- Reset (rst_n low, asynchronous): state IDLE; busy, done, sum, cout, ovf, zero = 0; internal shift registers, carry and bit counter = 0.
- FSM states:
  - IDLE: start=1 → SHIFT. On that edge, load a into shift reg A and b (or ~b when subtracting) into shift reg B. Load the carry reg with cin (or 1 when subtracting). Clear the counter to 0.
  - SHIFT: each cycle, the full-adder cell takes A[0], B[0] and the carry reg. Its sum bit shifts into the partial-sum reg MSB (the partial-sum reg shifts right). Its carry updates the carry reg. A and B shift right. The counter increments. Once the carry into bit WIDTH−1 has been computed, it is also held for ovf.
  - SHIFT → DONE on the edge that processes bit WIDTH−1 (counter == WIDTH−1). On that edge, sum, cout, ovf and zero are loaded from the internal state.
  - DONE: done=1 for exactly one cycle → IDLE unconditionally.
- start is ignored in SHIFT and DONE; there is no queuing. a, b, cin and op_sub are don't-care except on the accepting edge.
- sum, cout, ovf and zero hold their values from the last completed operation until the next DONE entry. They do not change during SHIFT.
- Arithmetic is modulo 2^WIDTH. ovf is defined for two's-complement operands in both add and subtract modes.
- Reset asserted mid-operation aborts immediately: all outputs return to 0 and no done pulse is produced.

## Timing
- Start accepted at edge T: busy=1 from T through T+WIDTH−1 (WIDTH cycles). State is DONE after edge T+WIDTH, so done=1 and the results are valid in the cycle after edge T+WIDTH.
- Latency from accepted start to done is WIDTH+1 cycles: 9 for WIDTH=8.
- Next start is accepted no earlier than the first IDLE cycle after done. Peak throughput is one operation per WIDTH+2 cycles.
- busy and done are never high in the same cycle.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - op_sub=1 inverts B on load and forces carry-in to 1, ignoring cin. The result is A − B.
  - op_sub=0 performs A + B + cin.
- SERIAL_ADDER_SUB_EN undefined:
  - The op_sub port exists but is ignored. The block always performs A + B + cin.
  - No inverter or carry-force logic is synthesised.

## Test plan
- Reset, then a=8'h3C, b=8'h42, cin=0, start pulse → done exactly 9 cycles later; sum=8'h7E, cout=0, ovf=0, zero=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, zero=1, ovf=0. Then a=8'h7F, b=8'h01 → sum=8'h80, ovf=1, cout=0.
- With SERIAL_ADDER_SUB_EN: a=8'h05, b=8'h07, op_sub=1 → sum=8'hFE, cout=0. Then a=8'h80, b=8'h01, op_sub=1 → sum=8'h7F, ovf=1, cout=1. Without the macro, the same op_sub=1 stimulus with a=8'h05, b=8'h07, cin=0 → sum=8'h0C.
- Start held high continuously through an operation → exactly one done per WIDTH+2 cycles. sum stays at the previous result while busy=1.
- Assert rst_n low 4 cycles after an accepted start → busy, done, sum, cout, ovf and zero read 0 immediately (asynchronously). No done pulse follows. A fresh start after release computes correctly.
- Randomised sweep of 1000 operand pairs for both modes, checked against the {cout, sum} reference arithmetic → zero mismatches.
